// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run controller for the PRBS-driven 4-bit sequence detector
// Sequences clear/seed/fill/compare steps on tick enables and reports match results.
module seq_detect_ctrl #(
  parameter int STEP_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              start,
  input  logic              abort,
  input  logic [3:0]        pattern,
  input  logic [STEP_W-1:0] max_steps,
  input  logic              bit_in,
  output logic              src_rst,
  output logic              src_seed,
  output logic              shift_en,
  output logic [3:0]        window,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic [STEP_W-1:0] first_idx,
  output logic              found,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SEED,
    S_FILL,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [3:0]        window_q, window_d;
  logic [3:0]        pattern_q, pattern_d;
  logic [STEP_W-1:0] max_q, max_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] first_q, first_d;
  logic [1:0]        fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              found_q, found_d;
  logic              match_q, match_d;
  logic              done_q, done_d;
  logic              src_rst_q, src_rst_d;
  logic              src_seed_q, src_seed_d;
  logic [3:0]        win_next;

  assign win_next = {window_q[2:0], bit_in};

  always_comb begin
    state_d    = state_q;
    window_d   = window_q;
    pattern_d  = pattern_q;
    max_d      = max_q;
    step_d     = step_q;
    first_d    = first_q;
    fill_d     = fill_q;
    cnt_d      = cnt_q;
    found_d    = found_q;
    match_d    = 1'b0;
    done_d     = 1'b0;
    src_rst_d  = 1'b0;
    src_seed_d = 1'b0;

    // Abort wins over tick and freezes every result where it stands.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pattern_d = pattern;
            max_d     = max_steps;
            window_d  = 4'b0000;
            cnt_d     = '0;
            first_d   = '0;
            found_d   = 1'b0;
            step_d    = '0;
            fill_d    = 2'd0;
            src_rst_d = 1'b1;
            state_d   = S_CLEAR;
          end
        end
        S_CLEAR: begin
          src_seed_d = 1'b1;
          state_d    = S_SEED;
        end
        S_SEED: begin
          state_d = S_FILL;
        end
        S_FILL: begin
          if (tick) begin
            window_d = win_next;
            fill_d   = fill_q + 2'd1;
            if (fill_q == 2'd3) begin
              if (max_q == '0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          if (tick) begin
            window_d = win_next;
            step_d   = step_q + STEP_W'(1);
            if (win_next == pattern_q) begin
              match_d = 1'b1;
              if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
              if (!found_q) begin
                first_d = step_q;
                found_d = 1'b1;
              end
            end
            if (step_q == max_q - STEP_W'(1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      window_q   <= 4'b0000;
      pattern_q  <= 4'b0000;
      max_q      <= '0;
      step_q     <= '0;
      first_q    <= '0;
      fill_q     <= 2'd0;
      cnt_q      <= '0;
      found_q    <= 1'b0;
      match_q    <= 1'b0;
      done_q     <= 1'b0;
      src_rst_q  <= 1'b0;
      src_seed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      window_q   <= window_d;
      pattern_q  <= pattern_d;
      max_q      <= max_d;
      step_q     <= step_d;
      first_q    <= first_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      found_q    <= found_d;
      match_q    <= match_d;
      done_q     <= done_d;
      src_rst_q  <= src_rst_d;
      src_seed_q <= src_seed_d;
    end
  end

  // Combinational so the datapath advances on the same edge the window samples bit_in.
  assign shift_en    = tick && !abort && !rst && (state_q == S_FILL || state_q == S_RUN);
  assign src_rst     = src_rst_q;
  assign src_seed    = src_seed_q;
  assign window      = window_q;
  assign match       = match_q;
  assign match_count = cnt_q;
  assign first_idx   = first_q;
  assign found       = found_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;

endmodule
